// File: rtl/instr_mix_sequencer.sv
// ---------------------------------------------------------------------------
// instr_mix_sequencer
//
// Fetches PROG_LEN MIPS instruction words from a synchronous instruction
// memory over a request/valid handshake. Each word is classified as R, I or J
// type, and its destination register is tallied for $3..$6. When the run
// finishes, the profile is shown on the LEDs; the switch selects the page.
//
// Parameters
//   PROG_LEN  instructions per run (1..64)
//   CNT_W     width of each class/destination counter (>= 3)
//
// Optional feature
//   SAT_COUNT_EN  when defined, counters saturate at 2^CNT_W-1;
//                 otherwise they wrap modulo 2^CNT_W.
//
// Ports
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   start       run request, honoured in IDLE and DONE only
//   imem_addr   word address of the current fetch
//   imem_rd     one-cycle read strobe (REQ state)
//   imem_data   instruction word, qualified by imem_valid
//   imem_valid  read data valid, honoured only in WAIT
//   switch      LED page: 0 = class counts, 1 = destination counts
//   busy        high in REQ, WAIT, DECODE
//   done        high in DONE
//   led         registered profile display, 8'h00 outside DONE
// ---------------------------------------------------------------------------
module instr_mix_sequencer #(
  parameter int PROG_LEN = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [5:0]  imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  input  logic        switch,
  output logic        busy,
  output logic        done,
  output logic [7:0]  led
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DECODE,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST_ADDR = 6'(PROG_LEN - 1);

  state_t           state_q, state_d;
  logic [5:0]       addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] r_q, r_d;
  logic [CNT_W-1:0] i_q, i_d;
  logic [CNT_W-1:0] j_q, j_d;
  logic [CNT_W-1:0] c3_q, c3_d;
  logic [CNT_W-1:0] c4_q, c4_d;
  logic [CNT_W-1:0] c5_q, c5_d;
  logic [CNT_W-1:0] c6_q, c6_d;
  logic [7:0]       led_q, led_d;

  logic [5:0]       opcode;
  logic             is_r;
  logic             is_j;
  logic [4:0]       dest;
  logic             run_req;

  // Only opcode, rt and rd take part in the profile.
  logic             unused_fields;
  assign unused_fields = ^{instr_q[25:21], instr_q[10:0]};

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef SAT_COUNT_EN
    return (&c) ? c : c + 1'b1;
`else
    return c + 1'b1;
`endif
  endfunction

  // Classification of the latched instruction word.
  always_comb begin
    opcode = instr_q[31:26];
    is_r   = (opcode == 6'd0);
    is_j   = (opcode == 6'd2) || (opcode == 6'd3);
    dest   = is_r ? instr_q[15:11] : instr_q[20:16];
  end

  // start only matters when no run is in flight.
  assign run_req = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_REQ;
      S_REQ:    state_d = S_WAIT;
      S_WAIT:   if (imem_valid) state_d = S_DECODE;
      S_DECODE: state_d = (addr_q == LAST_ADDR) ? S_DONE : S_REQ;
      S_DONE:   if (start) state_d = S_REQ;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    imem_rd = (state_q == S_REQ);
    busy    = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DECODE);
    done    = (state_q == S_DONE);
  end

  // Datapath: address, instruction latch, counters, LED page.
  always_comb begin
    addr_d  = addr_q;
    instr_d = instr_q;
    r_d     = r_q;
    i_d     = i_q;
    j_d     = j_q;
    c3_d    = c3_q;
    c4_d    = c4_q;
    c5_d    = c5_q;
    c6_d    = c6_q;
    led_d   = 8'h00;

    if (run_req) begin
      addr_d = 6'd0;
      r_d    = '0;
      i_d    = '0;
      j_d    = '0;
      c3_d   = '0;
      c4_d   = '0;
      c5_d   = '0;
      c6_d   = '0;
    end

    if ((state_q == S_WAIT) && imem_valid) begin
      instr_d = imem_data;
    end

    if (state_q == S_DECODE) begin
      if (is_r)      r_d = bump(r_q);
      else if (is_j) j_d = bump(j_q);
      else           i_d = bump(i_q);

      // jal writes $31 implicitly; J-type never counts a destination.
      if (!is_j) begin
        unique case (dest)
          5'd3:    c3_d = bump(c3_q);
          5'd4:    c4_d = bump(c4_q);
          5'd5:    c5_d = bump(c5_q);
          5'd6:    c6_d = bump(c6_q);
          default: ;
        endcase
      end

      if (addr_q != LAST_ADDR) addr_d = addr_q + 6'd1;
    end

    // The display is computed from the held counters while in DONE.
    if (state_q == S_DONE) begin
      if (switch) led_d = {c6_q[1:0], c5_q[1:0], c4_q[1:0], c3_q[1:0]};
      else        led_d = {j_q[1:0], i_q[2:0], r_q[2:0]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= 6'd0;
      instr_q <= 32'd0;
      r_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      c3_q    <= '0;
      c4_q    <= '0;
      c5_q    <= '0;
      c6_q    <= '0;
      led_q   <= 8'h00;
    end else begin
      addr_q  <= addr_d;
      instr_q <= instr_d;
      r_q     <= r_d;
      i_q     <= i_d;
      j_q     <= j_d;
      c3_q    <= c3_d;
      c4_q    <= c4_d;
      c5_q    <= c5_d;
      c6_q    <= c6_d;
      led_q   <= led_d;
    end
  end

  assign imem_addr = addr_q;
  assign led       = led_q;

endmodule

// File: tb/tb_instr_mix_sequencer.sv
`timescale 1ns/1ps
module tb_instr_mix_sequencer;

  localparam int PL  = 8;
  localparam int CW  = 4;
  localparam int PL2 = 20;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        sw = 1'b0;
  logic [5:0]  imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        busy, done;
  logic [7:0]  led;

  logic        start2 = 1'b0;
  logic [5:0]  addr2;
  logic        rd2;
  logic [31:0] data2;
  logic        valid2;
  logic        busy2, done2;
  logic [7:0]  led2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_mix_sequencer #(.PROG_LEN(PL), .CNT_W(CW)) u_dut (
    .clk(clk), .rstn(rstn), .start(start),
    .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_valid(imem_valid),
    .switch(sw), .busy(busy), .done(done), .led(led)
  );

  instr_mix_sequencer #(.PROG_LEN(PL2), .CNT_W(CW)) u_dut20 (
    .clk(clk), .rstn(rstn), .start(start2),
    .imem_addr(addr2), .imem_rd(rd2),
    .imem_data(data2), .imem_valid(valid2),
    .switch(sw), .busy(busy2), .done(done2), .led(led2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder for the main DUT ----------------
  logic [31:0] prog [64];
  int          lat_mode = 0;     // <0: random 0..3 extra wait cycles per fetch
  bit          noise_en = 1'b0;  // random valid/data outside WAIT
  bit          pend = 1'b0;
  int          wcnt = 0;
  logic [5:0]  paddr = '0;
  bit          acc_flag = 1'b0;  // a genuine word is offered this cycle
  logic [31:0] acc_word = '0;

  initial begin
    imem_valid = 1'b0;
    imem_data  = 32'd0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      acc_flag   = 1'b0;
      if (!rstn) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (wcnt == 0) begin
            imem_valid = 1'b1;
            imem_data  = prog[paddr];
            acc_flag   = 1'b1;
            acc_word   = prog[paddr];
            pend       = 1'b0;
          end else begin
            wcnt--;
          end
        end else if (noise_en && !imem_rd) begin
          imem_valid = 1'($urandom_range(0, 1));
          imem_data  = $urandom;
        end
        if (imem_rd) begin
          pend  = 1'b1;
          paddr = imem_addr;
          wcnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end
      end
    end
  end

  // ---------------- zero-wait responder for the 20-word DUT ----------------
  bit pend2 = 1'b0;
  initial begin
    valid2 = 1'b0;
    data2  = 32'h0000_1820;   // add $3,$0,$0
    forever begin
      @(negedge clk);
      valid2 = pend2;
      pend2  = rd2;
    end
  end

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
  mph_t ph = M_IDLE;
  int   nacc = 0;      // words accepted in this run
  bit   dec_now = 1'b0;
  int   tot [7];       // r, i, j, c3, c4, c5, c6 (unbounded totals)

  function automatic int lim(input int v);
`ifdef SAT_COUNT_EN
    return (v > (2**CW - 1)) ? (2**CW - 1) : v;
`else
    return v % (2**CW);
`endif
  endfunction

  function automatic logic [7:0] page(input logic s);
    logic [7:0] p;
    if (!s) begin
      p[2:0] = 3'(lim(tot[0]));
      p[5:3] = 3'(lim(tot[1]));
      p[7:6] = 2'(lim(tot[2]));
    end else begin
      p[1:0] = 2'(lim(tot[3]));
      p[3:2] = 2'(lim(tot[4]));
      p[5:4] = 2'(lim(tot[5]));
      p[7:6] = 2'(lim(tot[6]));
    end
    return p;
  endfunction

  task automatic tally(input logic [31:0] w);
    int op, d;
    op = int'(w[31:26]);
    if (op == 0) begin
      tot[0]++;
      d = int'(w[15:11]);
    end else if (op == 2 || op == 3) begin
      tot[2]++;
      d = -1;
    end else begin
      tot[1]++;
      d = int'(w[20:16]);
    end
    if (d >= 3 && d <= 6) tot[d]++;
  endtask

  // Compare process: samples just after each rising edge, where the inputs
  // seen are the ones the DUT has just sampled.
  initial begin
    foreach (tot[k]) tot[k] = 0;
    forever begin
      logic [7:0] exp_led;
      bit         rd_exp;
      @(posedge clk);
      #2;
      if (!rstn) begin
        ph = M_IDLE; nacc = 0; dec_now = 1'b0;
        foreach (tot[k]) tot[k] = 0;
        chk("reset_outputs", {15'd0, busy, done, imem_rd, led, imem_addr}, 32'd0);
      end else begin
        exp_led = (ph == M_DONE) ? page(sw) : 8'h00;
        rd_exp  = 1'b0;
        if (ph == M_RUN) begin
          if (dec_now) begin
            dec_now = 1'b0;
            if (nacc == PL) ph = M_DONE;
            else            rd_exp = 1'b1;
          end else if (acc_flag) begin
            tally(acc_word);
            nacc++;
            dec_now = 1'b1;
          end
        end else if (start) begin
          ph = M_RUN; nacc = 0; dec_now = 1'b0;
          foreach (tot[k]) tot[k] = 0;
          rd_exp = 1'b1;
        end
        chk("busy", {31'd0, busy}, {31'd0, ph == M_RUN});
        chk("done", {31'd0, done}, {31'd0, ph == M_DONE});
        chk("imem_rd", {31'd0, imem_rd}, {31'd0, rd_exp});
        chk("led", {24'd0, led}, {24'd0, exp_led});
        if (rd_exp) chk("imem_addr", {26'd0, imem_addr}, nacc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_dir();
    prog[0] = 32'h2004_0001;  // addi rt=4
    prog[1] = 32'h2005_0002;  // addi rt=5
    prog[2] = 32'h0005_2020;  // add  rd=4 (rt=5 must not count)
    prog[3] = 32'h0804_0000;  // j    (rt field 4 must not count)
    prog[4] = 32'h0C00_1800;  // jal  (rd field 3 must not count)
    prog[5] = 32'h8C06_0000;  // lw   rt=6
    prog[6] = 32'h0000_1820;  // add  rd=3
    prog[7] = 32'h3407_1800;  // ori  rt=7 (imm bits look like rd=3)
  endtask

  task automatic load_rand();
    for (int a = 0; a < PL; a++) begin
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 3))
        0:       w[31:26] = 6'd0;
        1:       w[31:26] = ($urandom_range(0, 1) != 0) ? 6'd2 : 6'd3;
        default: ;
      endcase
      w[20:16] = 5'($urandom_range(2, 7));
      w[15:11] = 5'($urandom_range(2, 7));
      prog[a] = w;
    end
  endtask

  // Pulses start and waits (bounded) for done; optionally jams start while busy.
  task automatic run_prog(input int bound, input bit jam, output int bcyc);
    int k;
    bcyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!done && k < bound) begin
      if (busy) bcyc++;
      @(negedge clk);
      k++;
      start = jam && !done && ($urandom_range(0, 5) == 0);
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: done=%0b after %0d cycles, expected 1", done, k);
    end
  endtask

  task automatic check_leds(input string tag, input logic [7:0] e0, input logic [7:0] e1);
    sw = 1'b0; @(negedge clk);
    chk({tag, "_led_sw0"}, {24'd0, led}, {24'd0, e0});
    sw = 1'b1; @(negedge clk);
    chk({tag, "_led_sw1"}, {24'd0, led}, {24'd0, e1});
    sw = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, k;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_outputs", {15'd0, busy, done, imem_rd, led, imem_addr}, 32'd0);
    rstn = 1'b1;

    // Idle with valid noise and no start: nothing may be fetched.
    noise_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_busy", {31'd0, busy}, 32'd0);

    // Directed program, zero-wait memory.
    load_dir();
    lat_mode = 0;
    run_prog(200, 1'b0, bc);
    chk("busy_cycles_zw", bc, 24);
    chk("model_r", tot[0], 2);
    chk("model_i", tot[1], 4);
    chk("model_j", tot[2], 2);
    chk("model_c3", tot[3], 1);
    chk("model_c4", tot[4], 2);
    chk("model_c5", tot[5], 1);
    chk("model_c6", tot[6], 1);
    check_leds("zw", 8'hA2, 8'h59);

    // Same program, five extra wait cycles per fetch.
    lat_mode = 5;
    run_prog(400, 1'b0, bc);
    chk("busy_cycles_slow", bc, 64);
    check_leds("slow", 8'hA2, 8'h59);

    // start jammed while busy, random latency; then restart from DONE.
    lat_mode = -1;
    run_prog(400, 1'b1, bc);
    check_leds("jam", 8'hA2, 8'h59);
    lat_mode = 0;
    run_prog(200, 1'b0, bc);
    chk("rerun_busy_cycles", bc, 24);
    check_leds("rerun", 8'hA2, 8'h59);

    // Reset while waiting on instruction 5.
    lat_mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(imem_rd && imem_addr == 6'd4) && k < 100) begin
      @(negedge clk); k++;
    end
    chk("reach_fetch4", {31'd0, imem_rd}, 32'd1);
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    chk("midrun_reset_outputs", {15'd0, busy, done, imem_rd, led, imem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    lat_mode = 0;
    run_prog(200, 1'b0, bc);
    chk("post_reset_busy_cycles", bc, 24);
    check_leds("post_reset", 8'hA2, 8'h59);

    // Random programs, random latency, random switch while in DONE.
    lat_mode = -1;
    for (int r = 0; r < 8; r++) begin
      load_rand();
      run_prog(400, (r % 2) == 1, bc);
      for (int s = 0; s < 4; s++) begin
        sw = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end

    // 20 R-type rd=3 words into 4-bit counters.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    k = 0; bc = 0;
    while (!done2 && k < 200) begin
      if (busy2) bc++;
      @(negedge clk); k++;
    end
    chk("dut20_done", {31'd0, done2}, 32'd1);
    chk("dut20_busy_cycles", bc, 60);
    sw = 1'b0; @(negedge clk);
`ifdef SAT_COUNT_EN
    chk("dut20_led_sw0", {24'd0, led2}, 32'h07);
`else
    chk("dut20_led_sw0", {24'd0, led2}, 32'h04);
`endif
    sw = 1'b1; @(negedge clk);
`ifdef SAT_COUNT_EN
    chk("dut20_led_sw1", {24'd0, led2}, 32'h03);
`else
    chk("dut20_led_sw1", {24'd0, led2}, 32'h00);
`endif
    sw = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_mix_sequencer.md
# instr_mix_sequencer

Sequences a 32-bit MIPS instruction stream out of a synchronous instruction memory and profiles it: each word is fetched over a request/valid handshake, classified as R-, I- or J-type, and its destination register tallied for $3–$6. The profile is shown on the board LEDs after the run, selected by a switch. The block sits between the instruction ROM and the LED/switch pins, replacing free-running counting with a start/busy/done-controlled run.

## Interface
- PROG_LEN, 8: number of instructions per run, 1..64
- CNT_W, 4: width of each class/destination counter, ≥3
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE and DONE only
- imem_addr  out  6  word address of current fetch
- imem_rd  out  1  one-cycle read strobe
- imem_data  in  32  instruction word, qualified by imem_valid
- imem_valid  in  1  read data valid, honoured only in WAIT
- switch  in  1  LED page select: 0 = class counts, 1 = destination counts
- busy  out  1  high in REQ, WAIT, DECODE
- done  out  1  high in DONE
- led  out  8  registered profile display

## Operation
- FSM states: IDLE, REQ, WAIT, DECODE, DONE.
- IDLE: start=1 → clear all counters, imem_addr=0, go REQ.
- REQ: imem_rd=1 for exactly this cycle → WAIT.
- WAIT: imem_rd=0; on imem_valid=1 latch imem_data into instr register → DECODE; otherwise stay (no re-request, no timeout).
- DECODE: classify instr, update counters; if imem_addr==PROG_LEN-1 → DONE, else imem_addr+1 → REQ.
- DONE: hold counters; start=1 → clear counters, imem_addr=0, REQ. start in busy states ignored.
- Classification on opcode instr[31:26]: 0 → R, dest=instr[15:11]; 2 or 3 → J, no dest counted (jal's $31 ignored); all others → I, dest=instr[20:16].
- Counters r, i, j, c3, c4, c5, c6 (CNT_W each); cN increments when dest==N. One class and at most one dest counter increment per DECODE.
- led (registered, 8'h00 outside DONE): switch=0 → led[2:0]=r[2:0], led[5:3]=i[2:0], led[7:6]=j[1:0]; switch=1 → led[1:0]=c3, [3:2]=c4, [5:4]=c5, [7:6]=c6 (low two bits each).

## Timing
- Reset (async, any state): state=IDLE, imem_addr=0, imem_rd=0, busy=0, done=0, led=8'h00, all counters and instr=0.
- start sampled at edge n → REQ during cycle n+1.
- Per instruction: REQ 1 + WAIT ≥1 + DECODE 1 cycles; zero-wait memory (valid the cycle after REQ) gives 3 cycles/instruction, 3·PROG_LEN cycles busy.
- done rises the cycle after the last DECODE; led valid one cycle later and follows switch with 1-cycle latency.
- imem_valid outside WAIT or in the same cycle as imem_rd is ignored.

## Configuration
- SAT_COUNT_EN defined: every counter saturates at 2^CNT_W−1.
- Not defined: counters wrap modulo 2^CNT_W.

## Test plan
- Reset: rstn low mid-sim → all outputs 0, state IDLE; imem_valid pulses without start → no fetch, counters 0.
- PROG_LEN=8, zero-wait memory, program {addi rt=4, addi rt=5, add rd=4, j, jal, lw rt=6, add rd=3, ori rt=7} → busy 24 cycles; r=2, i=4, j=2, c3=1, c4=2, c5=1, c6=1; led=8'hA2 (switch=0), 8'h59 (switch=1).
- Same program, imem_valid delayed 5 cycles per fetch → FSM holds WAIT, imem_rd single-cycle per address, identical counts and LEDs.
- start pulsed while busy → ignored; start in DONE → counters cleared, imem_addr=0, rerun gives identical results.
- PROG_LEN=20, CNT_W=4, 20× R-type rd=3 → r=c3=15 with SAT_COUNT_EN, r=c3=4 without.
- rstn asserted during WAIT of instruction 5 → immediate IDLE, imem_rd=0, counters 0; subsequent start runs cleanly from address 0.
